// File: rtl/key_dialer.sv
// key_dialer: keypad-side driver for the electronic lock.
// Replays a latched BCD code word as timed one-hot ten-key presses, then
// watches the lock's status to report whether the door opened. It also
// issues the single-cycle close strobe that re-locks the door.
// Optional feature macro: KEY_DIALER_RELOCK_EN. When defined, a successful
// entry holds the door open for TIMEOUT cycles and then closes it
// automatically, unless the lock has already re-locked itself.
module key_dialer #(
  parameter int NDIGIT    = 4,
  parameter int PRESS_CYC = 4,
  parameter int GAP_CYC   = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                ck,
  input  logic                reset,
  input  logic                start,
  input  logic [4*NDIGIT-1:0] code,
  input  logic                close_req,
  input  logic                lock,
  output logic [9:0]          tenkey,
  output logic                close,
  output logic                busy,
  output logic                done,
  output logic                err
);

  // One shared counter serves every timed state, so it is sized for the
  // longest of them. The digit index only has to reach NDIGIT-1.
  localparam int CMAX = (PRESS_CYC > GAP_CYC)
                        ? ((PRESS_CYC > TIMEOUT) ? PRESS_CYC : TIMEOUT)
                        : ((GAP_CYC > TIMEOUT) ? GAP_CYC : TIMEOUT);
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam int IW   = (NDIGIT > 1) ? $clog2(NDIGIT) : 1;

  localparam logic [CW-1:0] PRESS_LAST   = CW'(PRESS_CYC - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW-1:0] IDX_FIRST    = IW'(NDIGIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHECK_CODE,
    PRESS,
    GAP,
    WAIT_OPEN,
`ifdef KEY_DIALER_RELOCK_EN
    HOLD,
`endif
    CLOSE_P
  } state_t;

  state_t              state;
  logic [4*NDIGIT-1:0] code_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_dec;
  logic [CW-1:0]       cnt;
  logic [3:0]          cur_digit;
  logic [3:0]          next_digit;
  logic                code_bad;

  // Key n drives bit n of the ten-key bus; digits are already known to be 0..9.
  function automatic logic [9:0] key_bits(input logic [3:0] digit);
    return 10'b1 << digit;
  endfunction

  assign idx_dec    = idx - IW'(1);
  assign cur_digit  = code_q[{idx, 2'b00} +: 4];
  assign next_digit = code_q[{idx_dec, 2'b00} +: 4];

  // Flag a latched code that contains any nibble outside the BCD range.
  always_comb begin
    // NOTE: the default assignment first means every path writes code_bad, so no latch is inferred.
    code_bad = 1'b0;
    for (int i = 0; i < NDIGIT; i++) begin
      if (code_q[i*4 +: 4] > 4'd9) code_bad = 1'b1;
    end
  end

  // Sequencer: state, counters, latched code and all registered outputs.
  always_ff @(posedge ck or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      code_q <= '0;
      idx    <= '0;
      cnt    <= '0;
      tenkey <= '0;
      close  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments only; the pulse defaults below are overridden later in the same block.
      done  <= 1'b0;
      err   <= 1'b0;
      close <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            code_q <= code;
            idx    <= IDX_FIRST;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= CHECK_CODE;
          end else if (close_req) begin
            close <= 1'b1;
            busy  <= 1'b1;
            state <= CLOSE_P;
          end
        end
        CHECK_CODE: begin
          if (code_bad) begin
            err   <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            tenkey <= key_bits(cur_digit);
            cnt    <= '0;
            state  <= PRESS;
          end
        end
        PRESS: begin
          if (cnt == PRESS_LAST) begin
            tenkey <= '0;
            cnt    <= '0;
            state  <= GAP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt <= '0;
            if (idx != '0) begin
              idx    <= idx_dec;
              tenkey <= key_bits(next_digit);
              state  <= PRESS;
            end else begin
              state <= WAIT_OPEN;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        WAIT_OPEN: begin
          // A lock that opens on the last allowed cycle still counts as success.
          if (!lock) begin
            done <= 1'b1;
            cnt  <= '0;
`ifdef KEY_DIALER_RELOCK_EN
            state <= HOLD;
`else
            busy  <= 1'b0;
            state <= IDLE;
`endif
          end else if (cnt == TIMEOUT_LAST) begin
            err   <= 1'b1;
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`ifdef KEY_DIALER_RELOCK_EN
        HOLD: begin
          // The door re-locked on its own: nothing left to close.
          if (lock) begin
            cnt   <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (cnt == TIMEOUT_LAST) begin
            cnt   <= '0;
            close <= 1'b1;
            state <= CLOSE_P;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
`endif
        CLOSE_P: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          tenkey <= '0;
          cnt    <= '0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_dialer.sv
// tb_key_dialer: scoreboard bench for key_dialer.
// Stimulus predicts the timed event stream of each request from the
// protocol timing rules and pushes it into a queue; a monitor pops and
// compares whenever the DUT shows a key press, done, err or close.
// A behavioural lock opens a programmable delay after it has seen the
// secret code 6494 and re-locks on a close strobe.
module tb_key_dialer;

  localparam int NDIGIT    = 4;
  localparam int PRESS_CYC = 4;
  localparam int GAP_CYC   = 4;
  localparam int TIMEOUT   = 16;
  localparam int SLOT      = PRESS_CYC + GAP_CYC;
  localparam logic [4*NDIGIT-1:0] SECRET = 16'h6494;

  typedef enum int {EV_KEY, EV_DONE, EV_ERR, EV_CLOSE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       val;
    int       cyc;
  } ev_t;

  logic                ck;
  logic                reset;
  logic                start;
  logic [4*NDIGIT-1:0] code;
  logic                close_req;
  logic                lock;
  logic [9:0]          tenkey;
  logic                close;
  logic                busy;
  logic                done;
  logic                err;

  int  n_tests;
  int  n_fail;
  int  cyc;
  ev_t sb_q[$];
  int  lk_epoch;
  int  lk_delay;

  key_dialer #(
    .NDIGIT(NDIGIT), .PRESS_CYC(PRESS_CYC), .GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .ck(ck), .reset(reset), .start(start), .code(code), .close_req(close_req),
    .lock(lock), .tenkey(tenkey), .close(close), .busy(busy), .done(done), .err(err)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Edge count: at a falling edge, cyc is the number of rising edges so far.
  initial cyc = 0;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic sb_push(input ev_kind_t kind, input int val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.cyc  = at;
    sb_q.push_back(e);
  endtask

  task automatic sb_match(input ev_kind_t kind, input int val);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_%s: got value 0x%0h with nothing expected at cycle %0d",
               kind.name(), val, cyc);
    end else begin
      e = sb_q.pop_front();
      check("event_kind", int'(kind), int'(e.kind));
      check($sformatf("%s_value", e.kind.name()), val, e.val);
      check($sformatf("%s_cycle", e.kind.name()), cyc, e.cyc);
    end
  endtask

  // Monitor: turns DUT output activity into events and checks press shape.
  initial begin
    logic [9:0] prev_tk;
    int         run;
    prev_tk = '0;
    run     = 0;
    forever begin
      @(negedge ck);
      if (!reset) begin
        prev_tk = '0;
        run     = 0;
      end else begin
        if (tenkey != '0 && prev_tk == '0) begin
          check("tenkey_onehot", int'($onehot(tenkey)), 1);
          sb_match(EV_KEY, int'(tenkey));
          run = 1;
        end else if (tenkey != '0) begin
          if (tenkey != prev_tk) check("tenkey_stable", int'(tenkey), int'(prev_tk));
          run++;
        end else if (prev_tk != '0) begin
          check("press_length", run, PRESS_CYC);
        end
        prev_tk = tenkey;
        if (done || err) check("done_err_exclusive", int'(done & err), 0);
        if (done) begin
          sb_match(EV_DONE, 0);
`ifdef KEY_DIALER_RELOCK_EN
          check("busy_in_hold", int'(busy), 1);
`else
          check("busy_at_done", int'(busy), 0);
`endif
        end
        if (err) sb_match(EV_ERR, 0);
        if (close) sb_match(EV_CLOSE, 0);
      end
    end
  end

  // Behavioural lock: opens lk_delay cycles after the last key of the
  // secret, re-locks on close or when the bench starts a new request.
  initial begin
    int         seen;
    int         hist[$];
    int         fall_at;
    bit         armed;
    logic [9:0] prev_tk;
    logic [4*NDIGIT-1:0] secret_v;
    bit         match;
    secret_v = SECRET;
    seen     = 0;
    armed    = 1'b0;
    fall_at  = 0;
    prev_tk  = '0;
    lock     = 1'b1;
    forever begin
      @(negedge ck);
      if (lk_epoch != seen) begin
        seen = lk_epoch;
        hist.delete();
        armed = 1'b0;
        lock  = 1'b1;
      end
      if (reset && tenkey != '0 && prev_tk == '0) begin
        for (int d = 0; d < 10; d++) if (tenkey[d]) hist.push_back(d);
        if (hist.size() == NDIGIT) begin
          match = 1'b1;
          for (int k = 0; k < NDIGIT; k++)
            if (hist[k] != int'(secret_v[(NDIGIT-1-k)*4 +: 4])) match = 1'b0;
          if (match) begin
            armed   = 1'b1;
            fall_at = cyc + lk_delay;
          end
        end
      end
      if (armed && cyc == fall_at) begin
        lock  = 1'b0;
        armed = 1'b0;
      end
      if (reset && close) lock = 1'b1;
      prev_tk = reset ? tenkey : '0;
    end
  end

  task automatic wait_idle(input string name);
    int left;
    left = 200;
    while (busy && left > 0) begin
      @(negedge ck);
      left--;
    end
    if (busy) check({name, "_idle_timeout"}, int'(busy), 0);
    @(negedge ck);
    #1;
    check({name, "_queue_drained"}, sb_q.size(), 0);
  endtask

  // One code entry: predicts every event from the timing rules, then drives it.
  task automatic do_entry(input string name, input logic [4*NDIGIT-1:0] c,
                          input int d, input bit with_close, input bit noise);
    int n, wo, fall, dn;
    bit bad;
    lk_epoch++;
    lk_delay = d;
    @(negedge ck);
    start     = 1'b1;
    code      = c;
    close_req = with_close;
    n         = cyc + 1;
    bad = 1'b0;
    for (int i = 0; i < NDIGIT; i++) if (c[i*4 +: 4] > 4'd9) bad = 1'b1;
    if (bad) begin
      sb_push(EV_ERR, 0, n + 1);
    end else begin
      for (int k = 0; k < NDIGIT; k++)
        sb_push(EV_KEY, 1 << c[(NDIGIT-1-k)*4 +: 4], n + 1 + k*SLOT);
      wo = n + 1 + NDIGIT*SLOT;
      if (c == SECRET) begin
        fall = n + 1 + (NDIGIT-1)*SLOT + d + 1;
        dn   = (fall > wo + 1) ? fall : wo + 1;
        if (dn <= wo + TIMEOUT) begin
          sb_push(EV_DONE, 0, dn);
`ifdef KEY_DIALER_RELOCK_EN
          sb_push(EV_CLOSE, 0, dn + TIMEOUT);
`endif
        end else begin
          sb_push(EV_ERR, 0, wo + TIMEOUT);
        end
      end else begin
        sb_push(EV_ERR, 0, wo + TIMEOUT);
      end
    end
    @(negedge ck);
    start     = 1'b0;
    close_req = 1'b0;
    code      = 16'($urandom);
    check({name, "_busy_after_start"}, int'(busy), 1);
    if (bad) begin
      @(negedge ck);
      check({name, "_busy_one_cycle"}, int'(busy), 0);
      check({name, "_no_key"}, int'(tenkey), 0);
    end else if (noise) begin
      repeat (3) @(negedge ck);
      start     = 1'b1;
      close_req = 1'b1;
      code      = SECRET;
      @(negedge ck);
      start     = 1'b0;
      close_req = 1'b0;
    end
    wait_idle(name);
  endtask

  task automatic do_close(input string name);
    @(negedge ck);
    close_req = 1'b1;
    sb_push(EV_CLOSE, 0, cyc + 1);
    @(negedge ck);
    close_req = 1'b0;
    check({name, "_busy"}, int'(busy), 1);
    wait_idle(name);
  endtask

  task automatic random_code(output logic [4*NDIGIT-1:0] c, input bit bad);
    for (int i = 0; i < NDIGIT; i++) c[i*4 +: 4] = 4'($urandom_range(0, 9));
    if (bad) c[$urandom_range(0, NDIGIT-1)*4 +: 4] = 4'($urandom_range(10, 15));
  endtask

  initial begin
    int n, left, r;
    logic [4*NDIGIT-1:0] c;
    n_tests   = 0;
    n_fail    = 0;
    lk_epoch  = 0;
    lk_delay  = 0;
    reset     = 1'b0;
    start     = 1'b0;
    close_req = 1'b0;
    code      = '0;
    #1;
    check("reset_tenkey", int'(tenkey), 0);
    check("reset_close", int'(close), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    check("reset_err", int'(err), 0);
    repeat (3) @(negedge ck);
    #2 reset = 1'b1;

    // Correct code, start with a simultaneous close_req that must be dropped.
    do_entry("entry_6494", SECRET, 3, 1'b1, 1'b0);
    // Default build: the door stays open, no close follows done by itself.
    repeat (20) @(negedge ck);
    do_close("close_idle");
    do_entry("bad_12a4", 16'h12A4, 0, 1'b0, 1'b0);
    do_entry("timeout_0000", 16'h0000, 0, 1'b0, 1'b1);
    // Lock opens exactly on the last allowed WAIT_OPEN cycle.
    do_entry("late_open", SECRET, 23, 1'b0, 1'b0);
    // Lock opens one cycle too late.
    do_entry("too_late", SECRET, 24, 1'b0, 1'b0);

    // Asynchronous reset during the third press.
    lk_epoch++;
    @(negedge ck);
    start = 1'b1;
    code  = SECRET;
    n     = cyc + 1;
    for (int k = 0; k < 3; k++)
      sb_push(EV_KEY, 1 << SECRET[(NDIGIT-1-k)*4 +: 4], n + 1 + k*SLOT);
    @(negedge ck);
    start = 1'b0;
    left  = 100;
    while (cyc < n + 2*SLOT + 2 && left > 0) begin
      @(negedge ck);
      left--;
    end
    check("midreset_reached_press3", int'(tenkey), 1 << SECRET[(NDIGIT-3)*4 +: 4]);
    #2 reset = 1'b0;
    #1;
    check("midreset_tenkey", int'(tenkey), 0);
    check("midreset_busy", int'(busy), 0);
    check("midreset_queue", sb_q.size(), 0);
    sb_q.delete();
    repeat (2) @(negedge ck);
    #2 reset = 1'b1;
    do_entry("after_reset_8464", 16'h8464, 0, 1'b0, 1'b0);

    // Randomised traffic.
    for (int t = 0; t < 24; t++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        random_code(c, 1'b1);
        do_entry("rand_bad", c, 0, 1'(($urandom_range(0, 1))), 1'b0);
      end else if (r < 6) begin
        do_entry("rand_secret", SECRET, $urandom_range(0, 27),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end else if (r < 9) begin
        random_code(c, 1'b0);
        do_entry("rand_code", c, 0, 1'b0, 1'($urandom_range(0, 1)));
      end else begin
        do_close("rand_close");
      end
      repeat ($urandom_range(0, 3)) @(negedge ck);
    end

    repeat (5) @(negedge ck);
    check("final_queue_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d checks run", n_tests);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/key_dialer.md
Name: key_dialer

Overview:
- Keypad-side driver for the electronic lock; the transmitting end of the lock's tenkey/close interface.
- Takes a BCD code word and replays it as timed one-hot ten-key presses. Then watches the lock's `lock` output to report whether the lock opened.
- Also issues the single-cycle `close` strobe that re-locks the door.
- Used as a scripted keypad in system benches and as a service-entry controller in the lock subsystem.

Parameters:
- NDIGIT, 4: number of BCD digits sent per entry.
- PRESS_CYC, 4: cycles each key is held (one-hot active).
- GAP_CYC, 4: cycles tenkey is all-zero between presses and after the last press.
- TIMEOUT, 16: cycles allowed after the last gap for `lock` to fall to 0.

Ports:
- ck  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  single-cycle request; accepted only in IDLE.
- code  in  4*NDIGIT  BCD code; digit NDIGIT-1 (MS nibble) is sent first.
- close_req  in  1  request a close strobe; accepted only in IDLE.
- lock  in  1  lock status from the lock (1 = locked).
- tenkey  out  10  one-hot key drive to the lock; bit n = key n.
- close  out  1  close strobe to the lock.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse: entry finished and lock observed 0.
- err  out  1  one-cycle pulse: bad code or unlock timeout.

Behaviour:
- Reset: ck and reset as named; reset asynchronous, active-low. While reset=0:
  - tenkey=0, close=0, busy=0, done=0, err=0.
  - FSM=IDLE; all counters and the latched code cleared.
  - Reset asserted mid-sequence aborts immediately; no done or err is produced.
- All outputs are registered; no combinational path from inputs to outputs.
- FSM states: IDLE, CHECK_CODE, PRESS, GAP, WAIT_OPEN, CLOSE_P.
- IDLE:
  - start=1: latch code, digit index = NDIGIT-1, go to CHECK_CODE.
  - close_req=1 (start=0): go to CLOSE_P.
  - start and close_req both 1: start wins and close_req is dropped.
- CHECK_CODE (1 cycle):
  - Any latched nibble > 9: err=1 for one cycle, return to IDLE. tenkey never driven.
  - Otherwise go to PRESS.
- PRESS:
  - tenkey = 1<<digit for exactly PRESS_CYC cycles; exactly one bit set.
  - Then go to GAP.
- GAP:
  - tenkey=0 for exactly GAP_CYC cycles.
  - If digit index > 0: decrement index and go to PRESS.
  - If index = 0: go to WAIT_OPEN.
- WAIT_OPEN:
  - Counts up to TIMEOUT cycles.
  - First cycle with lock=0: done=1 next cycle, then IDLE.
  - Count reaches TIMEOUT with lock still 1: err=1 for one cycle, then IDLE.
  - lock=0 on the final count cycle counts as success.
- CLOSE_P: close=1 for exactly one cycle, then IDLE. Lock status is not checked.
- start and close_req arriving while busy=1 are ignored, not queued.
- The code input may change after the start cycle; only the latched copy is used.
- Entry latency, start to first tenkey bit: 2 cycles (CHECK_CODE plus output register).
- Full entry length: NDIGIT*(PRESS_CYC+GAP_CYC) cycles, then up to TIMEOUT cycles of WAIT_OPEN.
- Counters are sized from the parameters (clog2), with no wrap inside any state.
- done and err are never high in the same cycle.

Optional Feature:
- Macro: KEY_DIALER_RELOCK_EN.
- Defined:
  - After done, the FSM enters HOLD for TIMEOUT cycles; busy stays 1.
  - It then passes through CLOSE_P, producing one close pulse, and returns to IDLE.
  - If lock returns to 1 during HOLD, the close is skipped and the FSM goes straight to IDLE.
- Undefined: the HOLD state does not exist; after done the FSM goes directly to IDLE and the door stays open until close_req.

Test Plan:
- Code entry: reset pulse low, start with code=16'h6494, defaults, lock model accepts 6494 → tenkey = 0x040, 0x010, 0x200, 0x010, each held 4 cycles with 4-cycle zero gaps; lock falls; done pulses once; busy drops the cycle after.
- Bad code: code=16'h12A4 → err pulse 1 cycle after start; tenkey stays 0; busy high for exactly 1 cycle.
- Unlock timeout: code=16'h0000, lock tied 1 → all four presses of 0x001 sent; err pulses exactly 16 cycles after the last gap ends; no done.
- Close strobe: close_req while IDLE → close=1 for exactly one cycle. close_req while busy → no close pulse.
- Mid-sequence reset: reset=0 during the third PRESS → tenkey=0 and busy=0 immediately, without waiting for ck. After release, start with code 16'h8464 runs cleanly from the first digit.
- KEY_DIALER_RELOCK_EN build: successful 6494 entry → done, then close pulse 16 cycles later, lock returns 1. Without the macro, no close pulse follows done.
